ysyx_22050550_axi_arbiter: RTL and testbench

Two-requester AXI4 arbiter that shares the core's single external AXI master port between the instruction fetch unit (IFU, read only) and the load/store unit (LSU, read and write). It sits between the IFU/LSU uncached device ports and the top-level AXI interface. It serialises reads with round-robin arbitration, forwards LSU writes one transaction at a time, and holds LSU reads off while an LSU write is in flight so the LSU's own accesses stay ordered.

---
 rtl/ysyx_22050550_axi_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_ysyx_22050550_axi_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_axi_arbiter.sv
// Purpose : shares one AXI4 master port between the IFU (read only) and the LSU (read + write).
//           Reads are round-robin arbitrated; LSU writes are forwarded one transaction at a time.
// Latency : 1 cycle to grant a read; ar/r/aw/w/b are combinational pass-through once owned.
// Backpr. : ready/valid pass straight through to the owner; non-owners see valid = ready = 0.
// Ports   : io_ifu_ar/r  - IFU read master
//           io_lsu_ar/r, io_lsu_aw/w/b - LSU read and write master
//           io_axi_*     - downstream AXI master port (directions mirrored)
module ysyx_22050550_axi_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    // IFU read
    input  logic                io_ifu_ar_valid,
    output logic                io_ifu_ar_ready,
    input  logic [ADDR_W-1:0]   io_ifu_ar_addr,
    input  logic [7:0]          io_ifu_ar_len,
    input  logic [2:0]          io_ifu_ar_size,
    input  logic [1:0]          io_ifu_ar_burst,
    output logic                io_ifu_r_valid,
    input  logic                io_ifu_r_ready,
    output logic [DATA_W-1:0]   io_ifu_r_data,
    output logic [1:0]          io_ifu_r_resp,
    output logic                io_ifu_r_last,
    // LSU read
    input  logic                io_lsu_ar_valid,
    output logic                io_lsu_ar_ready,
    input  logic [ADDR_W-1:0]   io_lsu_ar_addr,
    input  logic [7:0]          io_lsu_ar_len,
    input  logic [2:0]          io_lsu_ar_size,
    input  logic [1:0]          io_lsu_ar_burst,
    output logic                io_lsu_r_valid,
    input  logic                io_lsu_r_ready,
    output logic [DATA_W-1:0]   io_lsu_r_data,
    output logic [1:0]          io_lsu_r_resp,
    output logic                io_lsu_r_last,
    // LSU write
    input  logic                io_lsu_aw_valid,
    output logic                io_lsu_aw_ready,
    input  logic [ADDR_W-1:0]   io_lsu_aw_addr,
    input  logic [7:0]          io_lsu_aw_len,
    input  logic [2:0]          io_lsu_aw_size,
    input  logic [1:0]          io_lsu_aw_burst,
    input  logic                io_lsu_w_valid,
    output logic                io_lsu_w_ready,
    input  logic [DATA_W-1:0]   io_lsu_w_data,
    input  logic [DATA_W/8-1:0] io_lsu_w_strb,
    input  logic                io_lsu_w_last,
    output logic                io_lsu_b_valid,
    input  logic                io_lsu_b_ready,
    output logic [1:0]          io_lsu_b_resp,
    // downstream AXI
    output logic                io_axi_ar_valid,
    input  logic                io_axi_ar_ready,
    output logic [ADDR_W-1:0]   io_axi_ar_addr,
    output logic [7:0]          io_axi_ar_len,
    output logic [2:0]          io_axi_ar_size,
    output logic [1:0]          io_axi_ar_burst,
    input  logic                io_axi_r_valid,
    output logic                io_axi_r_ready,
    input  logic [DATA_W-1:0]   io_axi_r_data,
    input  logic [1:0]          io_axi_r_resp,
    input  logic                io_axi_r_last,
    output logic                io_axi_aw_valid,
    input  logic                io_axi_aw_ready,
    output logic [ADDR_W-1:0]   io_axi_aw_addr,
    output logic [7:0]          io_axi_aw_len,
    output logic [2:0]          io_axi_aw_size,
    output logic [1:0]          io_axi_aw_burst,
    output logic                io_axi_w_valid,
    input  logic                io_axi_w_ready,
    output logic [DATA_W-1:0]   io_axi_w_data,
    output logic [DATA_W/8-1:0] io_axi_w_strb,
    output logic                io_axi_w_last,
    input  logic                io_axi_b_valid,
    output logic                io_axi_b_ready,
    input  logic [1:0]          io_axi_b_resp
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [1:0] r_rstate;
    logic [1:0] r_wstate;
    logic       r_gnt;      // read owner: 0 = IFU, 1 = LSU
    logic       r_last;     // previous read grantee

    // LSU reads wait for any in-flight LSU write so its accesses stay ordered.
    logic w_lsu_elig;
    logic w_any_req;
    logic w_next_gnt;
    logic w_lsu_win;

    assign w_lsu_elig = io_lsu_ar_valid && (r_wstate == W_IDLE);
    assign w_any_req  = io_ifu_ar_valid || w_lsu_elig;
    assign w_next_gnt = (io_ifu_ar_valid && w_lsu_elig) ? ~r_last : w_lsu_elig;
    // A read granted to the LSU this cycle takes precedence over a new LSU write.
    assign w_lsu_win  = (r_rstate == R_IDLE) && w_any_req && w_next_gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_any_req) begin
                    r_gnt    <= w_next_gnt;
                    r_last   <= w_next_gnt;
                    r_rstate <= R_ADDR;
                end
                R_ADDR: if (io_axi_ar_valid && io_axi_ar_ready) r_rstate <= R_DATA;
                R_DATA: if (io_axi_r_valid && io_axi_r_ready && io_axi_r_last) r_rstate <= R_IDLE;
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wstate <= W_IDLE;
        end else begin
            case (r_wstate)
                W_IDLE: if (io_lsu_aw_valid && !w_lsu_win) r_wstate <= W_ADDR;
                W_ADDR: if (io_axi_aw_valid && io_axi_aw_ready) r_wstate <= W_DATA;
                W_DATA: if (io_axi_w_valid && io_axi_w_ready && io_axi_w_last) r_wstate <= W_RESP;
                W_RESP: if (io_axi_b_valid && io_axi_b_ready) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read path mux: everything not owned is held at zero.
    always_comb begin
        io_axi_ar_valid = 1'b0;
        io_axi_ar_addr  = '0;
        io_axi_ar_len   = '0;
        io_axi_ar_size  = '0;
        io_axi_ar_burst = '0;
        io_ifu_ar_ready = 1'b0;
        io_lsu_ar_ready = 1'b0;
        io_axi_r_ready  = 1'b0;
        io_ifu_r_valid  = 1'b0;
        io_ifu_r_data   = '0;
        io_ifu_r_resp   = '0;
        io_ifu_r_last   = 1'b0;
        io_lsu_r_valid  = 1'b0;
        io_lsu_r_data   = '0;
        io_lsu_r_resp   = '0;
        io_lsu_r_last   = 1'b0;
        if (r_rstate == R_ADDR) begin
            if (r_gnt) begin
                io_axi_ar_valid = io_lsu_ar_valid;
                io_axi_ar_addr  = io_lsu_ar_addr;
                io_axi_ar_len   = io_lsu_ar_len;
                io_axi_ar_size  = io_lsu_ar_size;
                io_axi_ar_burst = io_lsu_ar_burst;
                io_lsu_ar_ready = io_axi_ar_ready;
            end else begin
                io_axi_ar_valid = io_ifu_ar_valid;
                io_axi_ar_addr  = io_ifu_ar_addr;
                io_axi_ar_len   = io_ifu_ar_len;
                io_axi_ar_size  = io_ifu_ar_size;
                io_axi_ar_burst = io_ifu_ar_burst;
                io_ifu_ar_ready = io_axi_ar_ready;
            end
        end
        if (r_rstate == R_DATA) begin
            if (r_gnt) begin
                io_lsu_r_valid = io_axi_r_valid;
                io_lsu_r_data  = io_axi_r_data;
                io_lsu_r_resp  = io_axi_r_resp;
                io_lsu_r_last  = io_axi_r_last;
                io_axi_r_ready = io_lsu_r_ready;
            end else begin
                io_ifu_r_valid = io_axi_r_valid;
                io_ifu_r_data  = io_axi_r_data;
                io_ifu_r_resp  = io_axi_r_resp;
                io_ifu_r_last  = io_axi_r_last;
                io_axi_r_ready = io_ifu_r_ready;
            end
        end
    end

    // Write path: only the channel matching the current write phase is open.
    always_comb begin
        io_axi_aw_valid = 1'b0;
        io_axi_aw_addr  = '0;
        io_axi_aw_len   = '0;
        io_axi_aw_size  = '0;
        io_axi_aw_burst = '0;
        io_lsu_aw_ready = 1'b0;
        io_axi_w_valid  = 1'b0;
        io_axi_w_data   = '0;
        io_axi_w_strb   = '0;
        io_axi_w_last   = 1'b0;
        io_lsu_w_ready  = 1'b0;
        io_lsu_b_valid  = 1'b0;
        io_lsu_b_resp   = '0;
        io_axi_b_ready  = 1'b0;
        case (r_wstate)
            W_ADDR: begin
                io_axi_aw_valid = io_lsu_aw_valid;
                io_axi_aw_addr  = io_lsu_aw_addr;
                io_axi_aw_len   = io_lsu_aw_len;
                io_axi_aw_size  = io_lsu_aw_size;
                io_axi_aw_burst = io_lsu_aw_burst;
                io_lsu_aw_ready = io_axi_aw_ready;
            end
            W_DATA: begin
                io_axi_w_valid  = io_lsu_w_valid;
                io_axi_w_data   = io_lsu_w_data;
                io_axi_w_strb   = io_lsu_w_strb;
                io_axi_w_last   = io_lsu_w_last;
                io_lsu_w_ready  = io_axi_w_ready;
            end
            W_RESP: begin
                io_lsu_b_valid  = io_axi_b_valid;
                io_lsu_b_resp   = io_axi_b_resp;
                io_axi_b_ready  = io_lsu_b_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050550_axi_arbiter.sv
module tb_ysyx_22050550_axi_arbiter;

    logic        clock, reset;
    logic        io_ifu_ar_valid, io_ifu_ar_ready;
    logic [63:0] io_ifu_ar_addr;
    logic [7:0]  io_ifu_ar_len;
    logic [2:0]  io_ifu_ar_size;
    logic [1:0]  io_ifu_ar_burst;
    logic        io_ifu_r_valid, io_ifu_r_ready, io_ifu_r_last;
    logic [63:0] io_ifu_r_data;
    logic [1:0]  io_ifu_r_resp;
    logic        io_lsu_ar_valid, io_lsu_ar_ready;
    logic [63:0] io_lsu_ar_addr;
    logic [7:0]  io_lsu_ar_len;
    logic [2:0]  io_lsu_ar_size;
    logic [1:0]  io_lsu_ar_burst;
    logic        io_lsu_r_valid, io_lsu_r_ready, io_lsu_r_last;
    logic [63:0] io_lsu_r_data;
    logic [1:0]  io_lsu_r_resp;
    logic        io_lsu_aw_valid, io_lsu_aw_ready;
    logic [63:0] io_lsu_aw_addr;
    logic [7:0]  io_lsu_aw_len;
    logic [2:0]  io_lsu_aw_size;
    logic [1:0]  io_lsu_aw_burst;
    logic        io_lsu_w_valid, io_lsu_w_ready, io_lsu_w_last;
    logic [63:0] io_lsu_w_data;
    logic [7:0]  io_lsu_w_strb;
    logic        io_lsu_b_valid, io_lsu_b_ready;
    logic [1:0]  io_lsu_b_resp;
    logic        io_axi_ar_valid, io_axi_ar_ready;
    logic [63:0] io_axi_ar_addr;
    logic [7:0]  io_axi_ar_len;
    logic [2:0]  io_axi_ar_size;
    logic [1:0]  io_axi_ar_burst;
    logic        io_axi_r_valid, io_axi_r_ready, io_axi_r_last;
    logic [63:0] io_axi_r_data;
    logic [1:0]  io_axi_r_resp;
    logic        io_axi_aw_valid, io_axi_aw_ready;
    logic [63:0] io_axi_aw_addr;
    logic [7:0]  io_axi_aw_len;
    logic [2:0]  io_axi_aw_size;
    logic [1:0]  io_axi_aw_burst;
    logic        io_axi_w_valid, io_axi_w_ready, io_axi_w_last;
    logic [63:0] io_axi_w_data;
    logic [7:0]  io_axi_w_strb;
    logic        io_axi_b_valid, io_axi_b_ready;
    logic [1:0]  io_axi_b_resp;

    int total = 0;
    int bad   = 0;

    ysyx_22050550_axi_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .io_ifu_ar_valid(io_ifu_ar_valid), .io_ifu_ar_ready(io_ifu_ar_ready),
        .io_ifu_ar_addr(io_ifu_ar_addr), .io_ifu_ar_len(io_ifu_ar_len),
        .io_ifu_ar_size(io_ifu_ar_size), .io_ifu_ar_burst(io_ifu_ar_burst),
        .io_ifu_r_valid(io_ifu_r_valid), .io_ifu_r_ready(io_ifu_r_ready),
        .io_ifu_r_data(io_ifu_r_data), .io_ifu_r_resp(io_ifu_r_resp), .io_ifu_r_last(io_ifu_r_last),
        .io_lsu_ar_valid(io_lsu_ar_valid), .io_lsu_ar_ready(io_lsu_ar_ready),
        .io_lsu_ar_addr(io_lsu_ar_addr), .io_lsu_ar_len(io_lsu_ar_len),
        .io_lsu_ar_size(io_lsu_ar_size), .io_lsu_ar_burst(io_lsu_ar_burst),
        .io_lsu_r_valid(io_lsu_r_valid), .io_lsu_r_ready(io_lsu_r_ready),
        .io_lsu_r_data(io_lsu_r_data), .io_lsu_r_resp(io_lsu_r_resp), .io_lsu_r_last(io_lsu_r_last),
        .io_lsu_aw_valid(io_lsu_aw_valid), .io_lsu_aw_ready(io_lsu_aw_ready),
        .io_lsu_aw_addr(io_lsu_aw_addr), .io_lsu_aw_len(io_lsu_aw_len),
        .io_lsu_aw_size(io_lsu_aw_size), .io_lsu_aw_burst(io_lsu_aw_burst),
        .io_lsu_w_valid(io_lsu_w_valid), .io_lsu_w_ready(io_lsu_w_ready),
        .io_lsu_w_data(io_lsu_w_data), .io_lsu_w_strb(io_lsu_w_strb), .io_lsu_w_last(io_lsu_w_last),
        .io_lsu_b_valid(io_lsu_b_valid), .io_lsu_b_ready(io_lsu_b_ready), .io_lsu_b_resp(io_lsu_b_resp),
        .io_axi_ar_valid(io_axi_ar_valid), .io_axi_ar_ready(io_axi_ar_ready),
        .io_axi_ar_addr(io_axi_ar_addr), .io_axi_ar_len(io_axi_ar_len),
        .io_axi_ar_size(io_axi_ar_size), .io_axi_ar_burst(io_axi_ar_burst),
        .io_axi_r_valid(io_axi_r_valid), .io_axi_r_ready(io_axi_r_ready),
        .io_axi_r_data(io_axi_r_data), .io_axi_r_resp(io_axi_r_resp), .io_axi_r_last(io_axi_r_last),
        .io_axi_aw_valid(io_axi_aw_valid), .io_axi_aw_ready(io_axi_aw_ready),
        .io_axi_aw_addr(io_axi_aw_addr), .io_axi_aw_len(io_axi_aw_len),
        .io_axi_aw_size(io_axi_aw_size), .io_axi_aw_burst(io_axi_aw_burst),
        .io_axi_w_valid(io_axi_w_valid), .io_axi_w_ready(io_axi_w_ready),
        .io_axi_w_data(io_axi_w_data), .io_axi_w_strb(io_axi_w_strb), .io_axi_w_last(io_axi_w_last),
        .io_axi_b_valid(io_axi_b_valid), .io_axi_b_ready(io_axi_b_ready), .io_axi_b_resp(io_axi_b_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called just after the grant edge: completes an ar handshake and one last beat.
    task automatic finish_read(input string pfx, input logic lsu,
                               input logic [63:0] addr, input logic [63:0] data);
        chk({pfx, "_ar_valid"}, io_axi_ar_valid, 1);
        chk({pfx, "_ar_addr"}, io_axi_ar_addr, addr);
        io_axi_ar_ready = 1'b1;
        #1;
        chk({pfx, "_ar_ready_own"}, lsu ? io_lsu_ar_ready : io_ifu_ar_ready, 1);
        chk({pfx, "_ar_ready_oth"}, lsu ? io_ifu_ar_ready : io_lsu_ar_ready, 0);
        tick();
        io_axi_ar_ready = 1'b0;
        if (lsu) io_lsu_ar_valid = 1'b0; else io_ifu_ar_valid = 1'b0;
        io_axi_r_valid = 1'b1;
        io_axi_r_data  = data;
        io_axi_r_last  = 1'b1;
        #1;
        chk({pfx, "_r_valid_own"}, lsu ? io_lsu_r_valid : io_ifu_r_valid, 1);
        chk({pfx, "_r_data_own"}, lsu ? io_lsu_r_data : io_ifu_r_data, data);
        chk({pfx, "_r_valid_oth"}, lsu ? io_ifu_r_valid : io_lsu_r_valid, 0);
        chk({pfx, "_ar_valid_dat"}, io_axi_ar_valid, 0);
        tick();
        io_axi_r_valid = 1'b0;
        io_axi_r_data  = '0;
        io_axi_r_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        io_ifu_ar_valid = 0; io_ifu_ar_addr = 0; io_ifu_ar_len = 0; io_ifu_ar_size = 3'd3; io_ifu_ar_burst = 2'd1;
        io_lsu_ar_valid = 0; io_lsu_ar_addr = 0; io_lsu_ar_len = 0; io_lsu_ar_size = 3'd3; io_lsu_ar_burst = 2'd1;
        io_ifu_r_ready = 1; io_lsu_r_ready = 1;
        io_lsu_aw_valid = 0; io_lsu_aw_addr = 0; io_lsu_aw_len = 0; io_lsu_aw_size = 3'd0; io_lsu_aw_burst = 2'd1;
        io_lsu_w_valid = 0; io_lsu_w_data = 0; io_lsu_w_strb = 0; io_lsu_w_last = 0; io_lsu_b_ready = 1;
        // slave side driven active during reset: nothing may leak through
        io_axi_ar_ready = 1; io_axi_r_valid = 1; io_axi_r_data = 64'h77; io_axi_r_resp = 0; io_axi_r_last = 1;
        io_axi_aw_ready = 1; io_axi_w_ready = 1; io_axi_b_valid = 1; io_axi_b_resp = 0;
        #2;
        chk("rst_axi_ar_valid", io_axi_ar_valid, 0);
        chk("rst_ifu_r_valid", io_ifu_r_valid, 0);
        chk("rst_lsu_r_valid", io_lsu_r_valid, 0);
        chk("rst_axi_r_ready", io_axi_r_ready, 0);
        chk("rst_lsu_aw_ready", io_lsu_aw_ready, 0);
        chk("rst_lsu_w_ready", io_lsu_w_ready, 0);
        chk("rst_lsu_b_valid", io_lsu_b_valid, 0);
        chk("rst_axi_b_ready", io_axi_b_ready, 0);
        tick(); tick();
        reset = 1'b1;
        io_axi_ar_ready = 0; io_axi_r_valid = 0; io_axi_r_data = 0; io_axi_r_last = 0;
        io_axi_aw_ready = 0; io_axi_w_ready = 0; io_axi_b_valid = 0;

        // Round robin from reset: IFU, LSU, IFU, LSU
        io_ifu_ar_valid = 1; io_ifu_ar_addr = 64'h8000_0100;
        io_lsu_ar_valid = 1; io_lsu_ar_addr = 64'h8000_0200;
        #1;
        chk("rr_idle_ar_valid", io_axi_ar_valid, 0);
        tick();
        finish_read("rr1", 1'b0, 64'h8000_0100, 64'h1111);
        io_ifu_ar_valid = 1;
        #1;
        chk("rr_gap_ar_valid", io_axi_ar_valid, 0);
        tick();
        finish_read("rr2", 1'b1, 64'h8000_0200, 64'h2222);
        io_lsu_ar_valid = 1;
        tick();
        finish_read("rr3", 1'b0, 64'h8000_0100, 64'h3333);
        tick();
        finish_read("rr4", 1'b1, 64'h8000_0200, 64'h4444);

        // IFU alone, len 0
        io_ifu_ar_valid = 1; io_ifu_ar_addr = 64'h8000_0000; io_ifu_ar_len = 0;
        #1;
        chk("ifu_pre_ar_valid", io_axi_ar_valid, 0);
        tick();
        finish_read("ifu", 1'b0, 64'h8000_0000, 64'hDEAD_BEEF);
        io_axi_r_valid = 1;
        #1;
        chk("ifu_idle_r_valid", io_ifu_r_valid, 0);
        chk("ifu_idle_r_ready", io_axi_r_ready, 0);
        io_axi_r_valid = 0;

        // LSU write with aw_ready delayed by 3 cycles
        io_lsu_aw_valid = 1; io_lsu_aw_addr = 64'hA000_03F8;
        io_lsu_w_valid = 1; io_lsu_w_data = 64'h41; io_lsu_w_strb = 8'h01; io_lsu_w_last = 1;
        #1;
        chk("wr_idle_aw_valid", io_axi_aw_valid, 0);
        tick();
        chk("wr_aw_addr", io_axi_aw_addr, 64'hA000_03F8);
        for (int i = 0; i < 3; i++) begin
            chk("wr_aw_valid_wait", io_axi_aw_valid, 1);
            chk("wr_aw_ready_low", io_lsu_aw_ready, 0);
            chk("wr_w_blocked", io_axi_w_valid, 0);
            tick();
        end
        io_axi_aw_ready = 1;
        #1;
        chk("wr_aw_ready_hi", io_lsu_aw_ready, 1);
        tick();
        io_lsu_aw_valid = 0; io_axi_aw_ready = 0;
        #1;
        chk("wr_aw_done", io_axi_aw_valid, 0);
        chk("wr_w_valid", io_axi_w_valid, 1);
        chk("wr_w_data", io_axi_w_data, 64'h41);
        chk("wr_w_strb", io_axi_w_strb, 8'h01);
        chk("wr_w_ready_low", io_lsu_w_ready, 0);
        io_axi_w_ready = 1;
        #1;
        chk("wr_w_ready_hi", io_lsu_w_ready, 1);
        tick();
        io_lsu_w_valid = 0; io_axi_w_ready = 0;
        io_axi_b_valid = 1;
        #1;
        chk("wr_w_done", io_axi_w_valid, 0);
        chk("wr_b_valid", io_lsu_b_valid, 1);
        chk("wr_b_ready", io_axi_b_ready, 1);
        tick();
        chk("wr_b_once", io_lsu_b_valid, 0);
        io_axi_b_valid = 0;

        // LSU read held while the write sits in W_RESP; IFU read overlaps
        io_lsu_aw_valid = 1; io_lsu_aw_addr = 64'hA000_0400;
        tick();
        io_axi_aw_ready = 1;
        tick();
        io_lsu_aw_valid = 0; io_axi_aw_ready = 0;
        io_lsu_w_valid = 1; io_axi_w_ready = 1;
        tick();
        io_lsu_w_valid = 0; io_axi_w_ready = 0;
        io_lsu_ar_valid = 1; io_lsu_ar_addr = 64'h8000_0300;
        io_ifu_ar_valid = 1; io_ifu_ar_addr = 64'h8000_0400;
        tick();
        finish_read("wresp_ifu", 1'b0, 64'h8000_0400, 64'h5555);
        chk("wresp_lsu_held0", io_axi_ar_valid, 0);
        tick();
        chk("wresp_lsu_held1", io_axi_ar_valid, 0);
        io_axi_b_valid = 1;
        #1;
        chk("wresp_b_valid", io_lsu_b_valid, 1);
        tick();
        io_axi_b_valid = 0;
        chk("wresp_no_grant_b", io_axi_ar_valid, 0);
        tick();
        finish_read("wresp_lsu", 1'b1, 64'h8000_0300, 64'h6666);

        // LSU read and write in the same idle cycle: read wins, write follows
        io_lsu_ar_valid = 1; io_lsu_ar_addr = 64'h8000_0500;
        io_lsu_aw_valid = 1; io_lsu_aw_addr = 64'hA000_0500;
        tick();
        chk("conf_aw_lost", io_axi_aw_valid, 0);
        finish_read("conf_lsu", 1'b1, 64'h8000_0500, 64'h7777);
        chk("conf_aw_later", io_axi_aw_valid, 1);
        io_axi_aw_ready = 1;
        tick();
        io_lsu_aw_valid = 0; io_axi_aw_ready = 0;
        io_lsu_w_valid = 1; io_axi_w_ready = 1;
        tick();
        io_lsu_w_valid = 0; io_axi_w_ready = 0; io_axi_b_valid = 1;
        tick();
        io_axi_b_valid = 0;

        // IFU burst of 4 beats with r_ready toggling
        io_ifu_ar_valid = 1; io_ifu_ar_addr = 64'h8000_1000; io_ifu_ar_len = 8'd3;
        tick();
        chk("bst_ar_valid", io_axi_ar_valid, 1);
        chk("bst_ar_len", io_axi_ar_len, 3);
        io_axi_ar_ready = 1;
        tick();
        io_axi_ar_ready = 0; io_ifu_ar_valid = 0;
        for (int i = 0; i < 4; i++) begin
            io_axi_r_valid = 1; io_axi_r_data = 64'h1000 + 64'(i); io_axi_r_last = (i == 3);
            io_ifu_r_ready = 0;
            #1;
            chk("bst_r_ready_low", io_axi_r_ready, 0);
            chk("bst_r_valid", io_ifu_r_valid, 1);
            tick();
            io_ifu_r_ready = 1;
            #1;
            chk("bst_r_data", io_ifu_r_data, 64'h1000 + 64'(i));
            chk("bst_r_last", io_ifu_r_last, (i == 3));
            tick();
        end
        chk("bst_idle_r_valid", io_ifu_r_valid, 0);
        chk("bst_gap_ar_valid", io_axi_ar_valid, 0);
        io_axi_r_valid = 0; io_axi_r_last = 0; io_axi_r_data = 0;

        // Reset in R_DATA of a len-3 burst
        io_ifu_ar_valid = 1; io_ifu_ar_addr = 64'h8000_2000; io_ifu_ar_len = 8'd3;
        tick();
        io_axi_ar_ready = 1;
        tick();
        io_axi_ar_ready = 0; io_ifu_ar_valid = 0;
        io_axi_r_valid = 1; io_axi_r_data = 64'h5000; io_axi_r_last = 0;
        #1;
        chk("mrst_r_valid_pre", io_ifu_r_valid, 1);
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_r_valid", io_ifu_r_valid, 0);
        chk("mrst_r_data", io_ifu_r_data, 0);
        chk("mrst_r_ready", io_axi_r_ready, 0);
        chk("mrst_ar_valid", io_axi_ar_valid, 0);
        tick();
        reset = 1'b1;
        io_axi_r_valid = 0; io_axi_r_data = 0;
        io_ifu_ar_valid = 1; io_ifu_ar_addr = 64'h8000_3000; io_ifu_ar_len = 0;
        #1;
        chk("mrst_new_pre", io_axi_ar_valid, 0);
        tick();
        finish_read("mrst_new", 1'b0, 64'h8000_3000, 64'h6000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
